// File: rtl/seq_pkg.sv
// Shared types, frame constants and frame-length helper for the seq_tx transmitter.
// Build option: SEQ_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } seq_tx_state_t;

  localparam logic SEQ_START_BIT = 1'b1;
  localparam logic SEQ_STOP_BIT  = 1'b0;

`ifdef SEQ_TX_PARITY_EN
  localparam bit SEQ_PARITY_EN = 1'b1;
`else
  localparam bit SEQ_PARITY_EN = 1'b0;
`endif

  function automatic int unsigned seq_frame_len(input int unsigned data_w,
                                                input int unsigned clks_per_bit,
                                                input bit          parity_en);
    return (2 + data_w + (parity_en ? 1 : 0)) * clks_per_bit;
  endfunction

endpackage

// File: rtl/seq_bit_timer.sv
// Bit-period timer: counts the clocks of one serial bit and pulses bit_done on its last cycle.
module seq_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_bit_done
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_done = i_en && (r_cnt == LAST);

  // The counter restarts at every bit boundary, so it never wraps inside a bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || !i_en || o_bit_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_tx.sv
// Bit-serial frame transmitter feeding sequencer.A: start bit, data LSB first, optional parity, stop.
// Build option: SEQ_TX_PARITY_EN enables the PARITY state (even parity over the latched word).
module seq_tx
  import seq_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              a,
  output logic              busy
);

  localparam int                BCNT_W   = $clog2(DATA_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  seq_tx_state_t     r_state;
  seq_tx_state_t     w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BCNT_W-1:0] r_bcnt;
  logic [BCNT_W-1:0] w_bcnt_nxt;
  logic              r_a;
  logic              w_a_nxt;
  logic              w_hs;
  logic              w_bit_done;
  logic              w_state_chg;
`ifdef SEQ_TX_PARITY_EN
  logic              r_par;
`endif

  assign tx_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign a           = r_a;
  assign w_hs        = tx_valid && tx_ready;
  assign w_state_chg = (w_state_nxt != r_state);

  seq_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .i_en      (busy),
    .i_clear   (w_state_chg),
    .o_bit_done(w_bit_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_state_nxt = START;
          w_shift_nxt = tx_data;
          w_bcnt_nxt  = '0;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bcnt == LAST_BIT) begin
`ifdef SEQ_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
            w_bcnt_nxt  = '0;
          end else begin
            w_bcnt_nxt  = r_bcnt + 1'b1;
          end
        end
      end
`ifdef SEQ_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The serial line is registered, so its next value is decoded from the next state.
  always_comb begin
    w_a_nxt = 1'b0;
    case (w_state_nxt)
      START:   w_a_nxt = SEQ_START_BIT;
      DATA:    w_a_nxt = w_shift_nxt[0];
`ifdef SEQ_TX_PARITY_EN
      PARITY:  w_a_nxt = r_par;
`endif
      STOP:    w_a_nxt = SEQ_STOP_BIT;
      default: w_a_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_a     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_a     <= w_a_nxt;
    end
  end

`ifdef SEQ_TX_PARITY_EN
  // Parity is taken from the word at handshake, before shifting consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_hs) begin
      r_par <= ^tx_data;
    end
  end
`endif

endmodule
